// File: rtl/qu_common.sv
// Processor-wide constants shared by all Qu pipeline stages.
package qu_common;

    localparam int QU_PHY_RF_DEPTH = 128;
    localparam int QU_TAG_W = $clog2(QU_PHY_RF_DEPTH);
    localparam int DISPATCH_QUEUE_DEPTH = 4;

endpackage

// File: rtl/qu_uop.sv
// Micro-op bundle types passed between Qu pipeline stages.
package qu_uop;

    import qu_common::*;

    typedef struct packed {
        logic [31:0]         pc;
        logic [15:0]         imm;
        logic [QU_TAG_W-1:0] rs1;
        logic [QU_TAG_W-1:0] rs2;
        logic [QU_TAG_W-1:0] rd;
        logic                rs1_valid;
        logic                rs2_valid;
        logic                rd_valid;
    } uop_ic_t;

    typedef struct packed {
        uop_ic_t    uop_ic;
        logic [3:0] fu_sel;
    } uop_t;

    typedef struct packed {
        uop_t uop;
        logic rs1_rdy;
        logic rs2_rdy;
    } dispatch_entry_t;

endpackage

// File: rtl/dispatch.sv
// Dispatch stage: in-order queue tracking source readiness between map and RS.
module dispatch
    import qu_common::*;
    import qu_uop::*;
#(
    parameter int PHY_RF_DEPTH = QU_PHY_RF_DEPTH,
    parameter int QUEUE_DEPTH  = DISPATCH_QUEUE_DEPTH,
    localparam int PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  uop_t                         uop_in,
    input  logic                         uop_in_valid,
    output logic                         full,
    output logic [PHY_RF_ADDR_WIDTH-1:0] busy_table_rs1_addr,
    output logic [PHY_RF_ADDR_WIDTH-1:0] busy_table_rs2_addr,
    input  logic                         busy_table_rs1_data,
    input  logic                         busy_table_rs2_data,
    input  logic                         wakeup_valid,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] wakeup_tag,
    output uop_t                         uop_out,
    output logic                         uop_out_valid,
    output logic                         uop_out_rs1_ready,
    output logic                         uop_out_rs2_ready,
    input  logic                         rs_ready
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    dispatch_entry_t entries_q [QUEUE_DEPTH];
    dispatch_entry_t entries_d [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic entry_valid [QUEUE_DEPTH];
    logic enq, deq;
    logic rs1_rdy_in, rs2_rdy_in;
    dispatch_entry_t head_e;

    assign full = (count_q == CNT_W'(QUEUE_DEPTH));
    assign enq  = en && uop_in_valid && !full;
    assign deq  = en && (count_q != '0) && rs_ready;

    assign busy_table_rs1_addr = uop_in.uop_ic.rs1;
    assign busy_table_rs2_addr = uop_in.uop_ic.rs2;

    assign rs1_rdy_in = !uop_in.uop_ic.rs1_valid || !busy_table_rs1_data
                        || (wakeup_valid && wakeup_tag == uop_in.uop_ic.rs1);
    assign rs2_rdy_in = !uop_in.uop_ic.rs2_valid || !busy_table_rs2_data
                        || (wakeup_valid && wakeup_tag == uop_in.uop_ic.rs2);

    // An entry is live when its distance from head is below count.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            entry_valid[i] = {1'b0, PTR_W'(i) - head_q} < count_q;
        end
    end

    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (entry_valid[i] && wakeup_valid) begin
                if (entries_q[i].uop.uop_ic.rs1_valid &&
                    entries_q[i].uop.uop_ic.rs1 == wakeup_tag)
                    entries_d[i].rs1_rdy = 1'b1;
                if (entries_q[i].uop.uop_ic.rs2_valid &&
                    entries_q[i].uop.uop_ic.rs2 == wakeup_tag)
                    entries_d[i].rs2_rdy = 1'b1;
            end
        end
        if (enq) begin
            entries_d[tail_q].uop     = uop_in;
            entries_d[tail_q].rs1_rdy = rs1_rdy_in;
            entries_d[tail_q].rs2_rdy = rs2_rdy_in;
        end
    end

    always_comb begin
        head_d  = deq ? head_q + 1'b1 : head_q;
        tail_d  = enq ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) entries_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) entries_q[i] <= entries_d[i];
        end
    end

    assign head_e        = entries_q[head_q];
    assign uop_out       = head_e.uop;
    assign uop_out_valid = en && (count_q != '0);

    // Same-cycle bypass so the RS sees a wakeup that lands on the head now.
    assign uop_out_rs1_ready = head_e.rs1_rdy
        || (wakeup_valid && head_e.uop.uop_ic.rs1_valid
            && wakeup_tag == head_e.uop.uop_ic.rs1);
    assign uop_out_rs2_ready = head_e.rs2_rdy
        || (wakeup_valid && head_e.uop.uop_ic.rs2_valid
            && wakeup_tag == head_e.uop.uop_ic.rs2);

endmodule

// File: tb/tb_dispatch.sv
// Directed scoreboard bench for the dispatch queue.
module tb_dispatch;

    import qu_common::*;
    import qu_uop::*;

    logic clk = 1'b0;
    logic rst, en, uop_in_valid, full;
    uop_t uop_in, uop_out;
    logic [6:0] bt_rs1_addr, bt_rs2_addr, wakeup_tag;
    logic bt_rs1_data, bt_rs2_data, wakeup_valid;
    logic uop_out_valid, uop_out_rs1_ready, uop_out_rs2_ready, rs_ready;

    logic busy [128];

    typedef struct {
        logic [15:0] imm;
        logic        r1;
        logic        r2;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign bt_rs1_data = busy[bt_rs1_addr];
    assign bt_rs2_data = busy[bt_rs2_addr];

    dispatch dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .uop_in              (uop_in),
        .uop_in_valid        (uop_in_valid),
        .full                (full),
        .busy_table_rs1_addr (bt_rs1_addr),
        .busy_table_rs2_addr (bt_rs2_addr),
        .busy_table_rs1_data (bt_rs1_data),
        .busy_table_rs2_data (bt_rs2_data),
        .wakeup_valid        (wakeup_valid),
        .wakeup_tag          (wakeup_tag),
        .uop_out             (uop_out),
        .uop_out_valid       (uop_out_valid),
        .uop_out_rs1_ready   (uop_out_rs1_ready),
        .uop_out_rs2_ready   (uop_out_rs2_ready),
        .rs_ready            (rs_ready)
    );

    function automatic uop_t mk(input logic [15:0] imm,
                                input logic [6:0] r1, input logic v1,
                                input logic [6:0] r2, input logic v2);
        uop_t u;
        u = '0;
        u.uop_ic.imm       = imm;
        u.uop_ic.pc        = {16'h0, imm} << 2;
        u.uop_ic.rs1       = r1;
        u.uop_ic.rs1_valid = v1;
        u.uop_ic.rs2       = r2;
        u.uop_ic.rs2_valid = v2;
        u.uop_ic.rd        = 7'd100;
        u.uop_ic.rd_valid  = 1'b1;
        return u;
    endfunction

    function automatic exp_t ex(input logic [15:0] imm,
                                input logic r1, input logic r2);
        exp_t e;
        e.imm = imm;
        e.r1  = r1;
        e.r2  = r2;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && uop_out_valid && rs_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got imm=%0d, expected no output",
                         uop_out.uop_ic.imm);
            end else begin
                e = sb.pop_front();
                if (uop_out.uop_ic.imm !== e.imm || uop_out_rs1_ready !== e.r1
                    || uop_out_rs2_ready !== e.r2) begin
                    errors++;
                    $display("FAIL sb_out: got imm=%0d r1=%0b r2=%0b, expected imm=%0d r1=%0b r2=%0b",
                             uop_out.uop_ic.imm, uop_out_rs1_ready,
                             uop_out_rs2_ready, e.imm, e.r1, e.r2);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) busy[i] = 1'b0;
        rst = 1'b1; en = 1'b1; uop_in = '0; uop_in_valid = 1'b0;
        wakeup_valid = 1'b0; wakeup_tag = '0; rs_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("reset_full", full, 0);
        chk("reset_valid", uop_out_valid, 0);
        chk("reset_rs1_ready", uop_out_rs1_ready, 0);
        chk("reset_rs2_ready", uop_out_rs2_ready, 0);

        // single uop, rs1 busy, rs2 free
        busy[5] = 1'b1;
        uop_in = mk(16'd1, 7'd5, 1, 7'd6, 1); uop_in_valid = 1'b1;
        sb.push_back(ex(16'd1, 0, 1));
        step();
        uop_in_valid = 1'b0;
        chk("single_valid", uop_out_valid, 1);
        chk("single_rs1", uop_out_rs1_ready, 0);
        chk("single_rs2", uop_out_rs2_ready, 1);
        rs_ready = 1'b1;
        step();
        rs_ready = 1'b0;
        chk("single_drained", uop_out_valid, 0);

        // fill to full, then try a 5th
        for (int k = 0; k < 4; k++) begin
            uop_in = mk(16'(10 + k), 7'd1, 1, 7'd2, 0); uop_in_valid = 1'b1;
            sb.push_back(ex(16'(10 + k), 1, 1));
            step();
        end
        chk("fill_full", full, 1);
        uop_in = mk(16'd14, 7'd1, 1, 7'd2, 1);
        step();
        chk("fill_refused_full", full, 1);
        rs_ready = 1'b1;
        step();
        rs_ready = 1'b0;
        chk("full_drop", full, 0);
        sb.push_back(ex(16'd14, 1, 1));
        step();
        uop_in_valid = 1'b0;
        chk("refill_full", full, 1);
        rs_ready = 1'b1;
        repeat (4) step();
        rs_ready = 1'b0;
        chk("fill_drained", uop_out_valid, 0);

        // wakeup bypass on the head
        busy[17] = 1'b1;
        uop_in = mk(16'd20, 7'd17, 1, 7'd0, 0); uop_in_valid = 1'b1;
        sb.push_back(ex(16'd20, 1, 1));
        step();
        uop_in_valid = 1'b0;
        chk("wake_before", uop_out_rs1_ready, 0);
        wakeup_valid = 1'b1; wakeup_tag = 7'd17;
        #1;
        chk("wake_bypass", uop_out_rs1_ready, 1);
        step();
        wakeup_valid = 1'b0;
        #1;
        chk("wake_stored", uop_out_rs1_ready, 1);
        rs_ready = 1'b1;
        step();
        rs_ready = 1'b0;

        // wakeup coinciding with enqueue
        busy[9] = 1'b1;
        uop_in = mk(16'd30, 7'd3, 0, 7'd9, 1); uop_in_valid = 1'b1;
        wakeup_valid = 1'b1; wakeup_tag = 7'd9;
        sb.push_back(ex(16'd30, 1, 1));
        step();
        uop_in_valid = 1'b0; wakeup_valid = 1'b0;
        chk("enq_wake_rs2", uop_out_rs2_ready, 1);
        rs_ready = 1'b1;
        step();
        rs_ready = 1'b0;

        // tag 0 wakeup captured while en=0
        busy[0] = 1'b1;
        uop_in = mk(16'd35, 7'd0, 1, 7'd4, 0); uop_in_valid = 1'b1;
        sb.push_back(ex(16'd35, 1, 1));
        step();
        uop_in_valid = 1'b0;
        chk("tag0_before", uop_out_rs1_ready, 0);
        en = 1'b0; wakeup_valid = 1'b1; wakeup_tag = 7'd0;
        #1;
        chk("en0_valid", uop_out_valid, 0);
        step();
        wakeup_valid = 1'b0; en = 1'b1;
        #1;
        chk("tag0_captured", uop_out_rs1_ready, 1);
        rs_ready = 1'b1;
        step();
        rs_ready = 1'b0;

        // streaming enqueue+dequeue, pointers wrap
        uop_in = mk(16'd40, 7'd1, 0, 7'd2, 0); uop_in_valid = 1'b1;
        sb.push_back(ex(16'd40, 1, 1));
        step();
        for (int k = 1; k < 10; k++) begin
            uop_in = mk(16'(40 + k), 7'd1, 0, 7'd2, 0);
            sb.push_back(ex(16'(40 + k), 1, 1));
            rs_ready = 1'b1;
            step();
            chk("stream_valid", uop_out_valid, 1);
            chk("stream_order", uop_out.uop_ic.imm, 40 + k);
            chk("stream_not_full", full, 0);
        end
        uop_in_valid = 1'b0;
        step();
        rs_ready = 1'b0;
        chk("stream_drained", uop_out_valid, 0);

        // reset discards a partly filled queue
        for (int k = 0; k < 3; k++) begin
            uop_in = mk(16'(50 + k), 7'd1, 0, 7'd2, 0); uop_in_valid = 1'b1;
            step();
        end
        uop_in_valid = 1'b0;
        chk("pre_reset_valid", uop_out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_reset_full", full, 0);
        chk("mid_reset_valid", uop_out_valid, 0);
        en = 1'b0; uop_in = mk(16'd60, 7'd1, 0, 7'd2, 0); uop_in_valid = 1'b1;
        step(); step();
        uop_in_valid = 1'b0; en = 1'b1;
        #1;
        chk("en0_no_enq", uop_out_valid, 0);

        step();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch.md
# dispatch

Dispatch stage of the Qu processor, directly downstream of `map`. It accepts renamed uops and looks up source-operand readiness in the busy table. Each uop is held in a small in-order queue with per-source ready bits, which are updated by result wakeups. The head uop is handed to the reservation station over a valid/ready handshake. `full` back-pressures `map` and everything upstream of it.

## Interface

Parameters:
- `PHY_RF_DEPTH`, 128: physical register count; tag width is `PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH)`.
- `QUEUE_DEPTH`, 4: queue entries; a power of two, ≥2.

Ports:
- `clk`  in  1: single clock. Everything is posedge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: stage enable; 0 freezes enqueue and dequeue.
- `uop_in`  in  uop_t: renamed uop from `map` (physical rs1/rs2/rd).
- `uop_in_valid`  in  1: `uop_in` is valid this cycle.
- `full`  out  1: queue cannot accept a uop this cycle.
- `busy_table_rs1_addr`, `busy_table_rs2_addr`  out  PHY_RF_ADDR_WIDTH: read addresses, driven from `uop_in.uop_ic.rs1/rs2`.
- `busy_table_rs1_data`, `busy_table_rs2_data`  in  1: combinational busy bits; 1 means the register is not yet written.
- `wakeup_valid`  in  1: a result is broadcast this cycle.
- `wakeup_tag`  in  PHY_RF_ADDR_WIDTH: physical register being written.
- `uop_out`  out  uop_t: head uop.
- `uop_out_valid`  out  1: head is valid and `en`=1.
- `uop_out_rs1_ready`, `uop_out_rs2_ready`  out  1: head source operands available.
- `rs_ready`  in  1: reservation station accepts `uop_out` this cycle.

## Operation

- Circular queue with `head` and `tail` pointers (`$clog2(QUEUE_DEPTH)` bits, natural wrap) and `count` (`$clog2(QUEUE_DEPTH)+1` bits).
- Each entry holds `{uop, rs1_rdy, rs2_rdy}`.
- `full = (count == QUEUE_DEPTH)`. This is purely registered state: a dequeue in the same cycle does not clear `full`.
- **Enqueue** fires when `en && uop_in_valid && !full`.
  - Write at `tail`, then `tail++`.
  - `rsN_rdy = !rsN_valid || !busy_table_rsN_data || (wakeup_valid && wakeup_tag == rsN)`.
- **Dequeue** fires when `en && count != 0 && rs_ready`; then `head++`.
- Enqueue and dequeue in the same cycle leave `count` unchanged.
- **Wakeup**: every valid stored entry whose `rsN_valid` is set and whose `rsN == wakeup_tag` sets `rsN_rdy`.
  - Wakeup acts regardless of `en`.
  - It also applies to an entry being enqueued or dequeued in the same cycle.
- Output signals:
  - `uop_out` is the head entry's uop.
  - `uop_out_valid = en && count != 0`.
  - `uop_out_rsN_ready` = stored `rsN_rdy` OR (`wakeup_valid && wakeup_tag == head.rsN && head.rsN_valid`); this is the same-cycle bypass.
- Dispatch does not wait for readiness; it forwards ready bits and the reservation station handles waiting.
- Dispatch never writes the busy table.

## Timing

- Reset values:
  - `count`, `head`, `tail` = 0.
  - All entry ready bits = 0.
  - `full` = 0, `uop_out_valid` = 0, `uop_out_rsN_ready` = 0.
  - `uop_out` = entry 0, which has no meaning while invalid.
- Latency: a uop enqueued in cycle N appears at `uop_out` with `uop_out_valid` = 1 in cycle N+1 (minimum one cycle, no bypass from input to output).
- `rst` asserted mid-operation discards every queued uop on the next edge. Reset wins over `en`, enqueue and wakeup.
- Boundary conditions:
  - Queue full with `rs_ready`=1: the dequeue completes, the input is refused, and `full` drops in the next cycle.
  - Queue empty: `uop_out_valid`=0, and `rs_ready` is ignored.
  - `en`=0: queue contents are held, `uop_out_valid`=0, wakeups are still captured.
  - `uop_in_valid`=1 while `full`: the uop is not consumed; the upstream stage holds it.
  - Wakeup tag 0: treated like any other tag.

## Structure

- Add `dispatch_entry_t` (`uop_t uop; logic rs1_rdy; logic rs2_rdy;`) to `qu_uop`.
- Default `QUEUE_DEPTH` goes in `qu_common`.
- Single module. The wakeup comparison is a per-entry loop, so no sub-module is needed.

## Test plan

- Reset, then enqueue one uop (rs1=5 busy, rs2=6 not busy): next cycle `uop_out_valid`=1, `rs1_ready`=0, `rs2_ready`=1. With `rs_ready`=1 the queue drains and `uop_out_valid`=0 the cycle after.
- Fill 4 entries with `rs_ready`=0: `full`=1 after the 4th. A 5th `uop_in_valid` is ignored. Pulse `rs_ready` once: `full`=0 next cycle, order preserved.
- Queued entry waiting on rs1=17: `wakeup_valid`, `wakeup_tag`=17 → `uop_out_rs1_ready`=1 in the same cycle (bypass) and stays 1.
- Enqueue a uop whose rs2=9 is busy while wakeup tag 9 fires in the same cycle → stored `rs2_rdy`=1.
- Sustained enqueue+dequeue every cycle for 10 uops: `count` stays 1, the pointers wrap, and uops emerge in order with one-cycle latency.
- Queue holding 3 entries, `rst` asserted for one cycle → `count`=0, `full`=0, `uop_out_valid`=0. With `en`=0, `uop_in_valid`=1 → nothing enqueued.
